// File: rtl/non_hwt_pkg.sv
// Shared types and helpers for the non_hwt pipelined reference gate.
// Holds the lane function, the default trigger and the select width rule.
package non_hwt_pkg;

    localparam logic [3:0] TRIG_DEF = 4'b1111;

    function automatic int sel_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic logic hwt_eval(
        input logic a,
        input logic b,
        input logic c,
        input logic d
    );
        return ((a & b) | c) & d;
    endfunction

endpackage

// File: rtl/non_hwt_pipe_counter.sv
// One lane's saturating rare-event counter.
// sat reports the next-state value at maximum so the parent can register it.
module rare_event_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] nxt;

    // Clear wins over a same-cycle increment; the count never wraps.
    always_comb begin
        nxt = cnt;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cnt != MAX)) begin
            nxt = cnt + CNT_W'(1);
        end
    end

    assign sat = (nxt == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/non_hwt_pipe.sv
// Pipelined, back-pressurable ((A&B)|C)&D gate with per-lane
// saturating trigger counters for trojan-activation monitoring.
module non_hwt_pipe
    import non_hwt_pkg::*;
#(
    parameter int         WIDTH  = 8,
    parameter int         STAGES = 2,
    parameter int         CNT_W  = 16,
    parameter logic [3:0] TRIG   = TRIG_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          A,
    input  logic [WIDTH-1:0]          B,
    input  logic [WIDTH-1:0]          C,
    input  logic [WIDTH-1:0]          D,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          Y,
    input  logic                      clr_cnt,
    input  logic [sel_w(WIDTH)-1:0]   cnt_sel,
    output logic [CNT_W-1:0]          rare_cnt,
    output logic                      rare_sat
);

    logic [STAGES-1:0]            v;
    logic [STAGES-1:0]            v_nxt;
    logic [STAGES-1:0]            load;
    logic [STAGES-1:0][WIDTH-1:0] d;
    logic [STAGES-1:0][WIDTH-1:0] d_nxt;
    logic [WIDTH-1:0]             f;
    logic                         accept;

    logic [WIDTH-1:0][CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]             sat_nxt;

    // A stage loads when empty or when its content moves on, so
    // bubbles collapse from the output side back to the input.
    always_comb begin : load_chain
        logic [STAGES-1:0] ld;
        ld = '0;
        ld[STAGES-1] = !v[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ld[k] = !v[k] | ld[k+1];
        end
        load = ld;
    end

    assign in_ready = load[0];
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign v_nxt[0] = load[0] ? in_valid : v[0];
            assign d_nxt[0] = accept ? f : d[0];
        end else begin : g_body
            assign v_nxt[k] = load[k] ? v[k-1] : v[k];
            assign d_nxt[k] = (load[k] && v[k-1]) ? d[k-1] : d[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            d <= '0;
        end else begin
            v <= v_nxt;
            d <= d_nxt;
        end
    end

    assign Y         = d[STAGES-1];
    assign out_valid = v[STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic hit;

        assign f[i] = hwt_eval(A[i], B[i], C[i], D[i]);
        assign hit  = accept && ({A[i], B[i], C[i], D[i]} == TRIG);

        rare_event_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (hit),
            .clr  (clr_cnt),
            .cnt  (cnt[i]),
            .sat  (sat_nxt[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rare_sat <= 1'b0;
        end else begin
            rare_sat <= |sat_nxt;
        end
    end

    always_comb begin
        rare_cnt = '0;
        if (int'(cnt_sel) < WIDTH) begin
            rare_cnt = cnt[cnt_sel];
        end
    end

endmodule

// File: tb/tb_non_hwt_pipe.sv
// Randomised self-checking bench for non_hwt_pipe.
// Two instances share stimulus: default counters and 4-bit counters.
module tb_non_hwt_pipe;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic         clr_cnt;
    logic [W-1:0] A, B, C, D;
    logic [2:0]   cnt_sel;

    logic         in_ready, out_valid, rare_sat;
    logic [W-1:0] Y;
    logic [15:0]  rare_cnt;
    logic         in_ready4, out_valid4, rare_sat4;
    logic [W-1:0] Y4;
    logic [3:0]   rare_cnt4;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit           sv [S];
    logic [W-1:0] sd [S];
    logic [W-1:0] q [$];
    int           c16 [W];
    int           c4 [W];
    bit           s16, s4;

    always #5 clk = ~clk;

    non_hwt_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .C(C), .D(D),
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y),
        .clr_cnt(clr_cnt), .cnt_sel(cnt_sel),
        .rare_cnt(rare_cnt), .rare_sat(rare_sat)
    );

    non_hwt_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4),
        .A(A), .B(B), .C(C), .D(D),
        .out_valid(out_valid4), .out_ready(out_ready), .Y(Y4),
        .clr_cnt(clr_cnt), .cnt_sel(cnt_sel),
        .rare_cnt(rare_cnt4), .rare_sat(rare_sat4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        for (int p = 0; p < S; p++) begin
            sv[p] = 1'b0;
            sd[p] = '0;
        end
        for (int i = 0; i < W; i++) begin
            c16[i] = 0;
            c4[i]  = 0;
        end
        q.delete();
        s16 = 1'b0;
        s4  = 1'b0;
    endtask

    // Drive one cycle, check pre-edge outputs, then advance the model.
    task automatic cycle(input logic iv, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [W-1:0] d, input logic ordy,
                         input logic clr, input logic [2:0] sel);
        bit full, exp_ir, acc, xfer;
        in_valid  = iv;
        A = a; B = b; C = c; D = d;
        out_ready = ordy;
        clr_cnt   = clr;
        cnt_sel   = sel;
        #1;
        full = 1'b1;
        for (int p = 0; p < S; p++) full &= sv[p];
        exp_ir = !(full && !ordy);
        chk("in_ready", in_ready, exp_ir);
        chk("in_ready4", in_ready4, exp_ir);
        chk("out_valid", out_valid, sv[S-1]);
        chk("out_valid4", out_valid4, sv[S-1]);
        if (sv[S-1]) chk("y", Y, sd[S-1]);
        chk("rare_cnt", rare_cnt, c16[sel]);
        chk("rare_cnt4", rare_cnt4, c4[sel]);
        chk("rare_sat", rare_sat, s16);
        chk("rare_sat4", rare_sat4, s4);
        acc  = iv && exp_ir;
        xfer = sv[S-1] && ordy;
        if (xfer) begin
            if (q.size() == 0) chk("spurious_out", 1, 0);
            else chk("order", Y, q.pop_front());
        end
        if (acc) q.push_back(((a & b) | c) & d);
        @(posedge clk);
        if (xfer) sv[S-1] = 1'b0;
        for (int p = S - 2; p >= 0; p--) begin
            if (sv[p] && !sv[p+1]) begin
                sv[p+1] = 1'b1;
                sd[p+1] = sd[p];
                sv[p]   = 1'b0;
            end
        end
        if (acc) begin
            sv[0] = 1'b1;
            sd[0] = ((a & b) | c) & d;
        end
        s16 = 1'b0;
        s4  = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (clr) begin
                c16[i] = 0;
                c4[i]  = 0;
            end else if (acc && a[i] && b[i] && c[i] && d[i]) begin
                if (c16[i] < 65535) c16[i]++;
                if (c4[i] < 15) c4[i]++;
            end
            if (c16[i] == 65535) s16 = 1'b1;
            if (c4[i] == 15) s4 = 1'b1;
        end
        #1;
    endtask

    initial begin
        int nacc;
        logic iv, ordy;
        logic [W-1:0] ra, rb, rc, rd;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        A = '0; B = '0; C = '0; D = '0; cnt_sel = '0;
        mreset();
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", Y, 0);
        chk("rst_cnt", rare_cnt, 0);
        chk("rst_sat", rare_sat, 0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed single beat
        cycle(1, 8'hF0, 8'hCC, 8'h01, 8'hFF, 1, 0, 0);
        cycle(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_y", Y, 8'hC1);
        cycle(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0);

        // Random stream with random back-pressure
        nacc = 0;
        for (int t = 0; t < 2000 && nacc < 100; t++) begin
            iv   = ($urandom_range(0, 9) < 7);
            ordy = $urandom_range(0, 1);
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 8'($urandom); rd = 8'($urandom);
            if (iv && !(sv[0] && sv[S-1] && !ordy)) nacc++;
            cycle(iv, ra, rb, rc, rd, ordy, 0, 3'($urandom_range(0, 7)));
        end
        chk("rand_accepts", nacc, 100);
        for (int t = 0; t < S + 2; t++)
            cycle(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        chk("drain_empty", q.size(), 0);

        // Per-lane counts and select range
        cycle(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0);
        for (int t = 0; t < 3; t++)
            cycle(1, 8'h05, 8'h05, 8'h05, 8'h05, 1, 0, 0);
        cnt_sel = 3'd0; #1 chk("sel0", rare_cnt, 3);
        cnt_sel = 3'd1; #1 chk("sel1", rare_cnt, 0);
        cnt_sel = 3'd2; #1 chk("sel2", rare_cnt, 3);
        cnt_sel = 3'(9); #1 chk("sel9", rare_cnt, 0);
        cycle(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0);

        // Saturation on the 4-bit instance
        cycle(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0);
        for (int t = 0; t < 20; t++)
            cycle(1, 8'h01, 8'h01, 8'h01, 8'h01, 1, 0, 0);
        chk("sat_cnt4", rare_cnt4, 15);
        chk("sat_cnt16", rare_cnt, 20);
        chk("sat_flag4", rare_sat4, 1);
        cycle(1, 8'h01, 8'h01, 8'h01, 8'h01, 1, 1, 0);
        chk("clr_cnt4", rare_cnt4, 0);
        chk("clr_flag4", rare_sat4, 0);
        cycle(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0);

        // Fill with a stalled output, then reset between edges
        for (int t = 0; t < S + 2; t++)
            cycle(1, 8'h01, 8'h01, 8'h01, 8'h01, 0, 0, 0);
        chk("full_stall", in_ready, 0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_y", Y, 0);
        chk("mid_rst_cnt", rare_cnt, 0);
        chk("mid_rst_cnt4", rare_cnt4, 0);
        chk("mid_rst_sat4", rare_sat4, 0);
        mreset();
        rst_n = 1'b1;
        #2;
        for (int t = 0; t < S + 3; t++)
            cycle(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
